ten_g_eth_axis_port_arb: RTL and testbench

//  N-channel, packet-level, round-robin AXI-Stream arbiter for the 10G MAC user side.

---
 rtl/ten_g_eth_pkg.sv | 29 ++
 rtl/ten_g_eth_axis_port_arb_if.sv | 43 ++++
 rtl/ten_g_eth_axis_skid.sv | 75 +++++++
 rtl/ten_g_eth_axis_port_arb.sv | 140 ++++++++++++++
 tb/tb_ten_g_eth_axis_port_arb.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ten_g_eth_pkg.sv
// Shared types and helpers for the 10G MAC user-side AXI-Stream port arbiter.
// Holds the arbiter state enum, default stream widths and the round-robin pick.
package ten_g_eth_pkg;

  localparam int ETH_DATA_W = 64;
  localparam int ETH_KEEP_W = ETH_DATA_W / 8;

  typedef enum logic [0:0] {
    IDLE,
    XFER
  } arb_state_e;

  // First set bit of req searching upward from ptr+1, wrapping at 16.
  // Callers zero-extend req, so unused high bits never win and the search
  // behaves as a wrap at the real port count.
  // The current ptr itself is tried last.
  function automatic logic [3:0] rr_next(
    input logic [15:0] req,
    input logic [3:0]  ptr
  );
    logic [3:0] idx;
    rr_next = ptr;
    for (int i = 16; i >= 1; i--) begin
      idx = ptr + 4'(i);
      if (req[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/ten_g_eth_axis_port_arb_if.sv
// Stream bundle for the port arbiter: NUM_PORTS input lanes, one uplink.
// slave = arbiter view, master = MAC FIFO / switch-core view.
interface ten_g_eth_axis_port_arb_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int DEST_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata;
  logic [NUM_PORTS*KEEP_W-1:0] s_axis_tkeep;
  logic [NUM_PORTS-1:0]        s_axis_tvalid;
  logic [NUM_PORTS-1:0]        s_axis_tlast;
  logic [NUM_PORTS-1:0]        s_axis_tready;

  logic [DATA_W-1:0]           m_axis_tdata;
  logic [KEEP_W-1:0]           m_axis_tkeep;
  logic [DEST_W-1:0]           m_axis_tdest;
  logic                        m_axis_tvalid;
  logic                        m_axis_tlast;
  logic                        m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep,
    input  s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep,
    output m_axis_tdest, m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep,
    output s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep,
    input  m_axis_tdest, m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/ten_g_eth_axis_skid.sv
// Registered 2-entry output buffer: in_* -> out_* with 1-cycle latency.
// Ports: clk/rst_n, in_{valid,ready,tdata,tkeep,tlast,tdest}, out_{...}.
module ten_g_eth_axis_skid #(
  parameter int DATA_W  = 64,
  parameter int TDEST_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_tdata,
  input  logic [DATA_W/8-1:0] in_tkeep,
  input  logic                in_tlast,
  input  logic [TDEST_W-1:0]  in_tdest,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_tdata,
  output logic [DATA_W/8-1:0] out_tkeep,
  output logic                out_tlast,
  output logic [TDEST_W-1:0]  out_tdest
);

  localparam int W = DATA_W + DATA_W/8 + 1 + TDEST_W;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_pay_q, out_pay_d;
  logic         sk_valid_q, sk_valid_d;
  logic [W-1:0] sk_pay_q, sk_pay_d;
  logic [W-1:0] in_pay;
  logic         in_fire;

  assign in_pay   = {in_tdata, in_tkeep, in_tlast, in_tdest};
  // Ready is a flop output: the skid slot absorbs the one beat
  // that arrives in the cycle the output stalls.
  assign in_ready = ~sk_valid_q;
  assign in_fire  = in_valid & ~sk_valid_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_pay_d   = out_pay_q;
    sk_valid_d  = sk_valid_q;
    sk_pay_d    = sk_pay_q;
    if (!out_valid_q || out_ready) begin
      if (sk_valid_q) begin
        out_valid_d = 1'b1;
        out_pay_d   = sk_pay_q;
        sk_valid_d  = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_pay_d = in_pay;
      end
    end else if (in_fire) begin
      sk_valid_d = 1'b1;
      sk_pay_d   = in_pay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pay_q   <= '0;
      sk_valid_q  <= 1'b0;
      sk_pay_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pay_q   <= out_pay_d;
      sk_valid_q  <= sk_valid_d;
      sk_pay_q    <= sk_pay_d;
    end
  end

  assign out_valid = out_valid_q;
  assign {out_tdata, out_tkeep, out_tlast, out_tdest} = out_pay_q;

endmodule

// File: rtl/ten_g_eth_axis_port_arb.sv
// Packet-level round-robin arbiter merging NUM_PORTS MAC RX streams into one uplink tagged by tdest.
// Ports: axis_aclk, axis_aresetn, port_en, axis (stream bundle), busy; frame_cnt with ARB_FRAME_CNT_EN.
module ten_g_eth_axis_port_arb
  import ten_g_eth_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = ETH_DATA_W,
  parameter int CNT_W     = 32
) (
  input  logic                 axis_aclk,
  input  logic                 axis_aresetn,
  input  logic [NUM_PORTS-1:0] port_en,
  ten_g_eth_axis_port_arb_if.slave axis,
  output logic                 busy
`ifdef ARB_FRAME_CNT_EN
  ,
  output logic [NUM_PORTS*CNT_W-1:0] frame_cnt
`endif
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(NUM_PORTS);

  arb_state_e           state_q, state_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 busy_q, busy_d;

  logic [NUM_PORTS-1:0] cand;
  logic [3:0]           pick;
  logic [NUM_PORTS-1:0] rdy;
  logic                 sel_valid;
  logic                 sel_last;
  logic [DATA_W-1:0]    sel_data;
  logic [KEEP_W-1:0]    sel_keep;
  logic                 sk_in_valid;
  logic                 sk_in_ready;

  assign cand      = axis.s_axis_tvalid & port_en;
  assign pick      = rr_next(16'(cand), 4'(rr_ptr_q));
  assign sel_valid = axis.s_axis_tvalid[grant_q];
  assign sel_last  = axis.s_axis_tlast[grant_q];
  assign sel_data  = axis.s_axis_tdata[grant_q*DATA_W +: DATA_W];
  assign sel_keep  = axis.s_axis_tkeep[grant_q*KEEP_W +: KEEP_W];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    busy_d      = busy_q;
    rdy         = '0;
    sk_in_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          grant_d  = pick[PTR_W-1:0];
          rr_ptr_d = pick[PTR_W-1:0];
          state_d  = XFER;
          busy_d   = 1'b1;
        end
      end
      XFER: begin
        // Only the granted port sees ready; port_en is not
        // consulted here, so a running frame always completes.
        rdy[grant_q] = sk_in_ready;
        sk_in_valid  = sel_valid;
        if (sel_valid && sk_in_ready && sel_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PTR_W'(NUM_PORTS - 1);
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign axis.s_axis_tready = rdy;
  assign busy               = busy_q;

  ten_g_eth_axis_skid #(
    .DATA_W  (DATA_W),
    .TDEST_W (PTR_W)
  ) u_skid (
    .clk       (axis_aclk),
    .rst_n     (axis_aresetn),
    .in_valid  (sk_in_valid),
    .in_ready  (sk_in_ready),
    .in_tdata  (sel_data),
    .in_tkeep  (sel_keep),
    .in_tlast  (sel_last),
    .in_tdest  (grant_q),
    .out_valid (axis.m_axis_tvalid),
    .out_ready (axis.m_axis_tready),
    .out_tdata (axis.m_axis_tdata),
    .out_tkeep (axis.m_axis_tkeep),
    .out_tlast (axis.m_axis_tlast),
    .out_tdest (axis.m_axis_tdest)
  );

`ifdef ARB_FRAME_CNT_EN
  logic [NUM_PORTS*CNT_W-1:0] cnt_q, cnt_d;
  logic                       eof_out;

  assign eof_out = axis.m_axis_tvalid & axis.m_axis_tready
                 & axis.m_axis_tlast;

  always_comb begin
    cnt_d = cnt_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (eof_out && axis.m_axis_tdest == PTR_W'(p)
          && cnt_q[p*CNT_W +: CNT_W] != {CNT_W{1'b1}})
        cnt_d[p*CNT_W +: CNT_W] = cnt_q[p*CNT_W +: CNT_W] + 1'b1;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) cnt_q <= '0;
    else               cnt_q <= cnt_d;
  end

  assign frame_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ten_g_eth_axis_port_arb.sv
// Scoreboard bench for the 10G port arbiter.
// Build with ARB_FRAME_CNT_EN to include the frame counter check.
module tb_ten_g_eth_axis_port_arb;

  localparam int NP = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  dest;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NP-1:0] port_en = '1;
  logic          busy;
`ifdef ARB_FRAME_CNT_EN
  logic [NP*4-1:0] frame_cnt;
`endif

  ten_g_eth_axis_port_arb_if #(.NUM_PORTS(NP), .DATA_W(64)) ax();

  ten_g_eth_axis_port_arb #(
    .NUM_PORTS (NP),
    .DATA_W    (64),
    .CNT_W     (4)
  ) dut (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .port_en      (port_en),
    .axis         (ax),
    .busy         (busy)
`ifdef ARB_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  beat_t src_q [NP][$];
  beat_t exp_q [$];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    fid = 0;
  bit    tog = 1'b0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] dut_out();
    return {ax.m_axis_tvalid, ax.m_axis_tlast, ax.m_axis_tkeep,
            ax.m_axis_tdata, ax.m_axis_tdest, busy,
            ax.s_axis_tready};
  endfunction

  function automatic void drive_src();
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        ax.s_axis_tdata[p*64 +: 64] = src_q[p][0].data;
        ax.s_axis_tkeep[p*8 +: 8]   = src_q[p][0].keep;
        ax.s_axis_tlast[p]          = src_q[p][0].last;
        ax.s_axis_tvalid[p]         = 1'b1;
      end else begin
        ax.s_axis_tdata[p*64 +: 64] = '0;
        ax.s_axis_tkeep[p*8 +: 8]   = '0;
        ax.s_axis_tlast[p]          = 1'b0;
        ax.s_axis_tvalid[p]         = 1'b0;
      end
    end
  endfunction

  task automatic send_frame(input int p, input int nb,
                            input logic [7:0] lkeep,
                            input bit push_exp);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.data = {8'(p), 8'(fid), 16'(i), 32'($urandom)};
      b.last = (i == nb - 1);
      b.keep = b.last ? lkeep : 8'hFF;
      b.dest = 2'(p);
      src_q[p].push_back(b);
      if (push_exp) exp_q.push_back(b);
    end
    fid++;
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
    drive_src();
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    port_en = '1;
    tog = 1'b0;
    clear_all();
    #1 check("rst_state", dut_out(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: timeout, %0d beats missing (required 0)",
               tag, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Source driver: handshake sampled mid-cycle, queues advanced after the edge.
  initial begin
    logic [NP-1:0] fire;
    ax.m_axis_tready = 1'b1;
    drive_src();
    forever begin
      @(negedge clk);
      fire = ax.s_axis_tvalid & ax.s_axis_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++)
        if (fire[p] && src_q[p].size() > 0)
          void'(src_q[p].pop_front());
      drive_src();
      ax.m_axis_tready = tog ? ~ax.m_axis_tready : 1'b1;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: scoreboard compare and stall-stability check.
  initial begin
    beat_t got, want, held;
    bit    hold_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_chk = 1'b0;
      end else begin
        got = {ax.m_axis_tdata, ax.m_axis_tkeep,
               ax.m_axis_tlast, ax.m_axis_tdest};
        if (hold_chk)
          check("hold", {ax.m_axis_tvalid, got}, {1'b1, held});
        if (ax.m_axis_tvalid && ax.m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", got, '0);
          end else begin
            want = exp_q.pop_front();
            check("beat", got, want);
          end
        end
        hold_chk = ax.m_axis_tvalid & ~ax.m_axis_tready;
        held = got;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, lo, n;
    bit seen_hi;

    // 1: single 3-beat frame from port 1, short last keep.
    do_reset();
    send_frame(1, 3, 8'h0F, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!ax.s_axis_tvalid[1] && n < 20);
    t0 = cyc;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!ax.m_axis_tvalid && n < 20);
    t1 = cyc;
    check("latency", t1 - t0, 2);
    wait_drain("t1_frame");

    // 2: all ports with two back-to-back 2-beat frames.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++)
        send_frame(p, 2, 8'hFF, 1'b1);
    lo = 0;
    seen_hi = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (busy) begin
        if (seen_hi && lo > 0) check("busy_gap", lo, 1);
        seen_hi = 1'b1;
        lo = 0;
      end else begin
        lo++;
      end
    end
    wait_drain("t2_rr");

    // 3: output ready toggling during a 4-beat frame.
    do_reset();
    tog = 1'b1;
    send_frame(0, 4, 8'h3F, 1'b1);
    wait_drain("t3_stall");
    tog = 1'b0;

    // 4: port 2 disabled mid-frame.
    do_reset();
    send_frame(2, 4, 8'hFF, 1'b1);
    n = 0;
    while (src_q[2].size() > 2 && n < 50) begin
      @(posedge clk); #3;
      n++;
    end
    port_en = 4'b1011;
    send_frame(2, 2, 8'h07, 1'b0);
    wait_drain("t4_finish");
    repeat (20) @(posedge clk);
    #3;
    check("skip_busy", busy, 0);
    check("skip_pending", src_q[2].size(), 2);
    send_frame(1, 2, 8'hFF, 1'b1);
    wait_drain("t4_port1");
    foreach (src_q[2][i]) exp_q.push_back(src_q[2][i]);
    port_en = 4'b1111;
    wait_drain("t4_reenable");
    check("reenable_done", src_q[2].size(), 0);

    // 5: reset on beat 2 of a 5-beat frame.
    do_reset();
    send_frame(2, 5, 8'hFF, 1'b1);
    n = 0;
    while (src_q[2].size() > 3 && n < 50) begin
      @(posedge clk); #3;
      n++;
    end
    rst_n = 1'b0;
    #1 check("rst_mid", dut_out(), '0);
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    send_frame(0, 2, 8'hFF, 1'b1);
    send_frame(3, 2, 8'h01, 1'b1);
    wait_drain("t5_after_rst");

`ifdef ARB_FRAME_CNT_EN
    // 6: counter saturation on port 3.
    do_reset();
    check("cnt_rst", frame_cnt, 0);
    for (int i = 0; i < 17; i++) send_frame(3, 1, 8'h01, 1'b1);
    wait_drain("t6_frames");
    check("cnt_sat", frame_cnt[15:12], 4'hF);
    check("cnt_other", frame_cnt[11:0], 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
